// File: rtl/shutdown_sequencer.sv
// Safety shutdown sequencer: merges watchdog, e-stop and over-temperature faults,
// latches the cause, stages motor/relay shutdown and gates restart on operator ack.
module shutdown_sequencer #(
  parameter int unsigned CLK_HZ         = 24000000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned RELAY_DELAY_MS = 100,
  parameter int unsigned ALARM_BLINK_MS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wdt_timeout,
  input  logic       estop_n,
  input  logic       overtemp,
  input  logic       ack,
  output logic       motor_en,
  output logic       power_relay,
  output logic       alarm,
  output logic [1:0] state,
  output logic [2:0] fault_code
);

  localparam int unsigned DEB_RAW = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DLY_RAW = CLK_HZ / 1000 * RELAY_DELAY_MS;
  localparam int unsigned BLK_RAW = CLK_HZ / 1000 * ALARM_BLINK_MS;
  localparam int unsigned DEB_CNT = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int unsigned DLY_CNT = (DLY_RAW < 1) ? 1 : DLY_RAW;
  localparam int unsigned BLK_CNT = (BLK_RAW < 1) ? 1 : BLK_RAW;
  localparam int unsigned DEB_W   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int unsigned DLY_W   = (DLY_CNT > 1) ? $clog2(DLY_CNT) : 1;
  localparam int unsigned BLK_W   = (BLK_CNT > 1) ? $clog2(BLK_CNT) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALT    = 2'd1,
    SAFE    = 2'd2,
    RECOVER = 2'd3
  } state_e;

  logic [1:0]       es_sync_q, ot_sync_q, ak_sync_q;
  logic             es_deb_q, ak_deb_q, ak_prev_q;
  logic [DEB_W-1:0] es_cnt_q, ak_cnt_q;
  state_e           state_q;
  logic [DLY_W-1:0] dly_q;
  logic [BLK_W-1:0] blk_q;
  logic [2:0]       fault_q;
  logic             motor_q, relay_q, alarm_q;

  logic       ack_rise;
  logic [2:0] cause;
  logic       fault_now;

  // Synchronisers: e-stop resets to released (high) so reset does not fake a fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      es_sync_q <= '1;
      ot_sync_q <= '0;
      ak_sync_q <= '0;
    end else begin
      es_sync_q <= {es_sync_q[0], estop_n};
      ot_sync_q <= {ot_sync_q[0], overtemp};
      ak_sync_q <= {ak_sync_q[0], ack};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      es_deb_q <= 1'b1;
      es_cnt_q <= '0;
    end else if (es_sync_q[1] == es_deb_q) begin
      es_cnt_q <= '0;
    end else if (es_cnt_q == DEB_W'(DEB_CNT - 1)) begin
      es_deb_q <= es_sync_q[1];
      es_cnt_q <= '0;
    end else begin
      es_cnt_q <= es_cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ak_deb_q  <= 1'b0;
      ak_cnt_q  <= '0;
      ak_prev_q <= 1'b0;
    end else begin
      ak_prev_q <= ak_deb_q;
      if (ak_sync_q[1] == ak_deb_q) begin
        ak_cnt_q <= '0;
      end else if (ak_cnt_q == DEB_W'(DEB_CNT - 1)) begin
        ak_deb_q <= ak_sync_q[1];
        ak_cnt_q <= '0;
      end else begin
        ak_cnt_q <= ak_cnt_q + DEB_W'(1);
      end
    end
  end

  assign ack_rise  = ak_deb_q & ~ak_prev_q;
  assign cause     = {ot_sync_q[1], ~es_deb_q, wdt_timeout};
  assign fault_now = |cause;

  // Outputs are assigned alongside each state transition so they move on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SAFE;
      dly_q   <= '0;
      blk_q   <= '0;
      fault_q <= '0;
      motor_q <= 1'b0;
      relay_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      fault_q <= fault_q | cause;
      case (state_q)
        RUN: begin
          if (fault_now) begin
            state_q <= HALT;
            dly_q   <= '0;
            motor_q <= 1'b0;
            relay_q <= 1'b1;
            alarm_q <= 1'b0;
          end
        end
        HALT: begin
          if (dly_q == DLY_W'(DLY_CNT - 1)) begin
            state_q <= SAFE;
            blk_q   <= '0;
            motor_q <= 1'b0;
            relay_q <= 1'b0;
            alarm_q <= 1'b1;
          end else begin
            dly_q <= dly_q + DLY_W'(1);
          end
        end
        SAFE: begin
          if (ack_rise && !fault_now) begin
            state_q <= RECOVER;
            fault_q <= '0;
            dly_q   <= '0;
            relay_q <= 1'b1;
            alarm_q <= 1'b0;
          end else if (fault_q == '0) begin
            // Fault arriving in an idle SAFE starts the blink high
            blk_q   <= '0;
            alarm_q <= fault_now;
          end else if (blk_q == BLK_W'(BLK_CNT - 1)) begin
            blk_q   <= '0;
            alarm_q <= ~alarm_q;
          end else begin
            blk_q <= blk_q + BLK_W'(1);
          end
        end
        RECOVER: begin
          if (fault_now) begin
            state_q <= HALT;
            dly_q   <= '0;
            motor_q <= 1'b0;
            relay_q <= 1'b1;
            alarm_q <= 1'b0;
          end else if (dly_q == DLY_W'(DLY_CNT - 1)) begin
            state_q <= RUN;
            motor_q <= 1'b1;
            relay_q <= 1'b1;
            alarm_q <= 1'b0;
          end else begin
            dly_q <= dly_q + DLY_W'(1);
          end
        end
        default: state_q <= SAFE;
      endcase
    end
  end

  assign motor_en    = motor_q;
  assign power_relay = relay_q;
  assign alarm       = alarm_q;
  assign state       = state_q;
  assign fault_code  = fault_q;

endmodule

// File: tb/tb_shutdown_sequencer.sv
// Directed plus random stimulus for shutdown_sequencer, checked every cycle against
// a timing model built from elapsed-cycle counts and run lengths.
module tb_shutdown_sequencer;

  localparam int DEB = 10;
  localparam int DLY = 20;
  localparam int BLK = 10;

  logic       clk = 1'b0;
  logic       rst, wdt_timeout, estop_n, overtemp, ack;
  logic       motor_en, power_relay, alarm;
  logic [1:0] state;
  logic [2:0] fault_code;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_st, m_el, m_bt, m_esr, m_akr;
  logic [2:0] m_fault;
  logic [1:0] m_es, m_ot, m_ak;
  logic       m_esd, m_akd, m_akp;

  shutdown_sequencer #(
    .CLK_HZ(10000),
    .DEBOUNCE_MS(1),
    .RELAY_DELAY_MS(2),
    .ALARM_BLINK_MS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wdt_timeout(wdt_timeout),
    .estop_n(estop_n),
    .overtemp(overtemp),
    .ack(ack),
    .motor_en(motor_en),
    .power_relay(power_relay),
    .alarm(alarm),
    .state(state),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 2; m_el = 0; m_bt = 0; m_esr = 0; m_akr = 0;
    m_fault = 3'b000;
    m_es = 2'b11; m_ot = 2'b00; m_ak = 2'b00;
    m_esd = 1'b1; m_akd = 1'b0; m_akp = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled
  task automatic model_edge();
    logic [2:0] cz, nf;
    logic       fn, rise;
    cz   = {m_ot[1], ~m_esd, wdt_timeout};
    fn   = |cz;
    rise = m_akd & ~m_akp;
    nf   = m_fault | cz;
    case (m_st)
      0: if (fn) begin m_st = 1; m_el = 0; end
      1: begin
        m_el++;
        if (m_el == DLY) begin m_st = 2; m_bt = 0; end
      end
      2: begin
        if (rise && !fn) begin m_st = 3; nf = 3'b000; m_el = 0; end
        else if (m_fault == 3'b000) m_bt = 0;
        else m_bt++;
      end
      default: begin
        if (fn) begin m_st = 1; m_el = 0; end
        else begin
          m_el++;
          if (m_el == DLY) m_st = 0;
        end
      end
    endcase
    m_fault = nf;
    m_akp = m_akd;
    if (m_es[1] != m_esd) begin
      m_esr++;
      if (m_esr == DEB) begin m_esd = m_es[1]; m_esr = 0; end
    end else m_esr = 0;
    if (m_ak[1] != m_akd) begin
      m_akr++;
      if (m_akr == DEB) begin m_akd = m_ak[1]; m_akr = 0; end
    end else m_akr = 0;
    m_es = {m_es[0], estop_n};
    m_ot = {m_ot[0], overtemp};
    m_ak = {m_ak[0], ack};
  endtask

  task automatic check_all();
    logic exp_alarm;
    exp_alarm = (m_st == 2 && m_fault != 3'b000) ? (((m_bt / BLK) % 2) == 0) : 1'b0;
    chk("state", 8'(state), 8'(m_st));
    chk("motor_en", 8'(motor_en), 8'(m_st == 0));
    chk("power_relay", 8'(power_relay), 8'(m_st != 2));
    chk("alarm", 8'(alarm), 8'(exp_alarm));
    chk("fault_code", 8'(fault_code), 8'(m_fault));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; wdt_timeout = 1'b0; estop_n = 1'b1; overtemp = 1'b0; ack = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Startup: ack long enough to debounce, then RECOVER dwell into RUN
    ack = 1'b1; run(15);
    ack = 1'b0; run(40);

    // Watchdog trip from RUN, then blinking SAFE
    wdt_timeout = 1'b1; run(1);
    wdt_timeout = 1'b0; run(45);
    ack = 1'b1; run(15);
    ack = 1'b0; run(30);

    // E-stop bounce shorter than the debounce, then a real press
    estop_n = 1'b0; run(5);
    estop_n = 1'b1; run(15);
    estop_n = 1'b0; run(12);
    estop_n = 1'b1; run(40);

    // Ack blocked by an active over-temperature, then accepted once clear
    overtemp = 1'b1; run(5);
    ack = 1'b1; run(15);
    ack = 1'b0; run(15);
    overtemp = 1'b0; run(5);
    ack = 1'b1; run(15);
    ack = 1'b0; run(10);

    // One-cycle over-temperature while in RECOVER
    overtemp = 1'b1; run(1);
    overtemp = 1'b0; run(40);
    ack = 1'b1; run(15);
    ack = 1'b0; run(30);

    // Asynchronous reset in the middle of HALT
    wdt_timeout = 1'b1; run(1);
    wdt_timeout = 1'b0; run(6);
    #2 rst = 1'b1;
    #1;
    chk("async_state", 8'(state), 8'd2);
    chk("async_motor", 8'(motor_en), 8'd0);
    chk("async_relay", 8'(power_relay), 8'd0);
    chk("async_alarm", 8'(alarm), 8'd0);
    chk("async_fault", 8'(fault_code), 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      wdt_timeout = ($urandom_range(0, 299) == 0);
      if (estop_n) begin
        if ($urandom_range(0, 119) == 0) estop_n = 1'b0;
      end else if ($urandom_range(0, 14) == 0) estop_n = 1'b1;
      if (overtemp) begin
        if ($urandom_range(0, 9) == 0) overtemp = 1'b0;
      end else if ($urandom_range(0, 199) == 0) overtemp = 1'b1;
      if ($urandom_range(0, 24) == 0) ack = ~ack;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
